// File: rtl/detector_jogada.sv
// Button input conditioning: 2-flop synchronizer, optional debounce filter
// (enabled by DETECTOR_JOGADA_DEBOUNCE_EN), multi-press rejection, press-then-release.
module detector_jogada #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic       jogada,
  output logic [3:0] jogada_code,
  output logic       multiplo,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    FILTRO  = 3'd1,
    PULSO   = 3'd2,
    SOLTA   = 3'd3,
    REJEITA = 3'd4
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [3:0] sinc1_q, sinc_q;
  logic [3:0] amostra_q, amostra_d;
  logic [3:0] code_q, code_d;
  logic [1:0] vale_q;
  logic       armado_q;

  function automatic logic um_bit(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  localparam logic [CNT_W-1:0] CntFim = CNT_W'(DEB_CYCLES - 1);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1_q   <= 4'd0;
      sinc_q    <= 4'd0;
      amostra_q <= 4'd0;
      code_q    <= 4'd0;
      estado_q  <= ESPERA;
      vale_q    <= 2'b00;
      armado_q  <= 1'b0;
    end else begin
      sinc1_q   <= botoes;
      sinc_q    <= sinc1_q;
      amostra_q <= amostra_d;
      code_q    <= code_d;
      estado_q  <= estado_d;
      // After reset the chain must carry real levels and see all buttons
      // released before a press is accepted, so a held button is ignored.
      vale_q    <= {vale_q[0], 1'b1};
      armado_q  <= armado_q | (vale_q[1] & (sinc_q == 4'd0));
    end
  end

`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    estado_d  = estado_q;
    amostra_d = amostra_q;
    code_d    = code_q;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
    cnt_d     = cnt_q;
`endif
    case (estado_q)
      ESPERA: begin
        if (habilita && armado_q && (sinc_q != 4'd0)) begin
          amostra_d = sinc_q;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
          cnt_d    = '0;
          estado_d = FILTRO;
`else
          estado_d = um_bit(sinc_q) ? PULSO : REJEITA;
`endif
        end
      end
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
      FILTRO: begin
        if (!habilita || (sinc_q != amostra_q)) begin
          cnt_d    = '0;
          estado_d = ESPERA;
        end else if (cnt_q == CntFim) begin
          estado_d = um_bit(amostra_q) ? PULSO : REJEITA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      PULSO: begin
        code_d   = amostra_q;
        estado_d = SOLTA;
      end
      REJEITA: estado_d = SOLTA;
      SOLTA: begin
        if (sinc_q == 4'd0) estado_d = ESPERA;
      end
      default: estado_d = ESPERA;
    endcase
  end

  assign jogada      = (estado_q == PULSO);
  assign multiplo    = (estado_q == REJEITA);
  assign jogada_code = code_q;
  assign db_estado   = {1'b0, estado_q};

endmodule

// File: tb/tb_detector_jogada.sv
// Directed self-checking bench for detector_jogada (works with or without
// DETECTOR_JOGADA_DEBOUNCE_EN).
module tb_detector_jogada;

  localparam int DEB = 4;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
  localparam int LAT    = DEB + 3;
  localparam int RST_AT = 4;
`else
  localparam int LAT    = 3;
  localparam int RST_AT = 2;
`endif
  localparam int HAB_LAT = LAT - 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes = 4'd0;
  logic       habilita = 1'b0;
  logic       jogada, multiplo;
  logic [3:0] jogada_code, db_estado;

  int comparacoes = 0;
  int erros = 0;

  detector_jogada #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .botoes(botoes), .habilita(habilita),
    .jogada(jogada), .jogada_code(jogada_code), .multiplo(multiplo),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drive a press right after an edge; edge i is the i-th edge after that.
  task automatic run_press(input logic [3:0] b, input logic [3:0] old_code, input string nm);
    int pulsos;
    logic [3:0] exp_db;
    botoes = b;
    for (int i = 1; i <= LAT + 1; i++) begin
      tick();
      exp_db = (i < 3) ? 4'd0 : (i < LAT) ? 4'd1 : (i == LAT) ? 4'd2 : 4'd3;
      comparacoes++;
      if (db_estado !== exp_db) begin
        erros++;
        $display("FAIL %s db_estado edge %0d: got %0d want %0d", nm, i, db_estado, exp_db);
      end
      comparacoes++;
      if (jogada !== (i == LAT)) begin
        erros++;
        $display("FAIL %s jogada edge %0d: got %b want %b", nm, i, jogada, (i == LAT));
      end
      if (i == LAT) begin
        comparacoes++;
        if (jogada_code !== old_code) begin
          erros++;
          $display("FAIL %s code_before: got %b want %b", nm, jogada_code, old_code);
        end
      end
      if (i == LAT + 1) begin
        comparacoes++;
        if (jogada_code !== b) begin
          erros++;
          $display("FAIL %s code_after: got %b want %b", nm, jogada_code, b);
        end
      end
    end
    pulsos = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (jogada || multiplo) pulsos++;
    end
    comparacoes++;
    if (pulsos !== 0) begin
      erros++;
      $display("FAIL %s extra_pulses: got %0d want 0", nm, pulsos);
    end
    botoes = 4'd0;
    repeat (4) tick();
    comparacoes++;
    if (db_estado !== 4'd0) begin
      erros++;
      $display("FAIL %s release_state: got %0d want 0", nm, db_estado);
    end
  endtask

  task automatic test_reset;
    repeat (2) tick();
    comparacoes++;
    if ({jogada, multiplo, jogada_code, db_estado} !== 10'd0) begin
      erros++;
      $display("FAIL reset_outputs: got j=%b m=%b c=%b s=%0d want all 0",
               jogada, multiplo, jogada_code, db_estado);
    end
    reset = 1'b0;
    repeat (5) tick();
    comparacoes++;
    if (db_estado !== 4'd0) begin
      erros++;
      $display("FAIL reset_idle_state: got %0d want 0", db_estado);
    end
  endtask

  task automatic test_clean_press;
    habilita = 1'b1;
    run_press(4'b0100, 4'b0000, "clean");
  endtask

  task automatic test_bounce;
`ifdef DETECTOR_JOGADA_DEBOUNCE_EN
    int pulsos = 0;
    for (int i = 0; i < 10; i++) begin
      botoes = ((i / 2) % 2 == 1) ? 4'b0010 : 4'b0000;
      tick();
      if (jogada || multiplo) pulsos++;
    end
    comparacoes++;
    if (pulsos !== 0) begin
      erros++;
      $display("FAIL bounce_pulses: got %0d want 0", pulsos);
    end
    run_press(4'b0010, 4'b0100, "bounce");
`else
    // Without the filter a one-cycle glitch is still a valid play.
    botoes = 4'b0010;
    tick();
    botoes = 4'b0000;
    tick(); tick();
    comparacoes++;
    if (jogada !== 1'b1) begin
      erros++;
      $display("FAIL glitch_jogada: got %b want 1", jogada);
    end
    tick();
    comparacoes++;
    if (jogada_code !== 4'b0010) begin
      erros++;
      $display("FAIL glitch_code: got %b want 0010", jogada_code);
    end
    repeat (4) tick();
    comparacoes++;
    if (db_estado !== 4'd0) begin
      erros++;
      $display("FAIL glitch_release: got %0d want 0", db_estado);
    end
`endif
  endtask

  task automatic test_multi;
    int jp = 0;
    int mp = 0;
    botoes = 4'b1001;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (jogada) jp++;
      if (multiplo) mp++;
      if (i == LAT) begin
        comparacoes++;
        if (db_estado !== 4'd4 || multiplo !== 1'b1) begin
          erros++;
          $display("FAIL multi_rejeita: got s=%0d m=%b want s=4 m=1", db_estado, multiplo);
        end
      end
    end
    comparacoes++;
    if (mp !== 1 || jp !== 0) begin
      erros++;
      $display("FAIL multi_counts: got multiplo=%0d jogada=%0d want 1/0", mp, jp);
    end
    comparacoes++;
    if (jogada_code !== 4'b0010) begin
      erros++;
      $display("FAIL multi_code: got %b want 0010", jogada_code);
    end
    botoes = 4'd0;
    repeat (4) tick();
  endtask

  task automatic test_hold_disable;
    int pulsos = 0;
    int fora = 0;
    habilita = 1'b0;
    botoes = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (jogada || multiplo) pulsos++;
      if (db_estado !== 4'd0) fora++;
    end
    comparacoes++;
    if (pulsos !== 0 || fora !== 0) begin
      erros++;
      $display("FAIL disabled: got pulses=%0d nonidle=%0d want 0/0", pulsos, fora);
    end
    habilita = 1'b1;
    for (int i = 1; i <= HAB_LAT; i++) begin
      tick();
      comparacoes++;
      if (jogada !== (i == HAB_LAT)) begin
        erros++;
        $display("FAIL enable_rise edge %0d: got %b want %b", i, jogada, (i == HAB_LAT));
      end
    end
    pulsos = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (jogada || multiplo) pulsos++;
    end
    comparacoes++;
    if (pulsos !== 0) begin
      erros++;
      $display("FAIL hold_100: got %0d want 0", pulsos);
    end
    comparacoes++;
    if (jogada_code !== 4'b0001) begin
      erros++;
      $display("FAIL hold_code: got %b want 0001", jogada_code);
    end
    botoes = 4'd0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid;
    int pulsos = 0;
    int fora = 0;
    botoes = 4'b1000;
    repeat (RST_AT) tick();
    comparacoes++;
    if (jogada !== 1'b0) begin
      erros++;
      $display("FAIL mid_prereset: got jogada=%b want 0", jogada);
    end
    reset = 1'b1;
    #1;
    comparacoes++;
    if ({jogada, multiplo, jogada_code, db_estado} !== 10'd0) begin
      erros++;
      $display("FAIL mid_reset_outputs: got j=%b m=%b c=%b s=%0d want all 0",
               jogada, multiplo, jogada_code, db_estado);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (jogada || multiplo) pulsos++;
      if (db_estado !== 4'd0) fora++;
    end
    comparacoes++;
    if (pulsos !== 0 || fora !== 0) begin
      erros++;
      $display("FAIL mid_held: got pulses=%0d nonidle=%0d want 0/0", pulsos, fora);
    end
    botoes = 4'd0;
    repeat (5) tick();
    run_press(4'b1000, 4'b0000, "repress");
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
      end
    join_none
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_hold_disable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparacoes, erros);
    $finish;
  end

endmodule
